// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one result per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is only accepted in IDLE/DONE and is ignored while busy.
//
// Ports:
//   clk, rst_n   sole clock, synchronous active-low reset
//   start        request pulse; A, B and sign are sampled on the accepting edge
//   A, B         multiplicand / multiplier (WIDTH bits)
//   sign         1 = two's-complement operands, 0 = unsigned
//   busy         high while iterating (RUN)
//   done         one-cycle pulse in DONE; C is valid with it
//   C            2*WIDTH-bit product, held until the next completion
//
// Build option: define MUL_ITER_SIGNED_EN to honour the sign port. Without it
// every operation is unsigned and no sign-correction logic is built.

module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 sign,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH:0]       mcand_q;   // multiplicand magnitude (WIDTH+1 bits)
    // acc_q[2W:W] is the running partial sum, acc_q[W-1:0] holds the
    // not-yet-consumed multiplier bits; both shift right together each step.
    logic [2*WIDTH:0]     acc_q;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH:0]       a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH+1:0]     sum;
    logic [2*WIDTH:0]     acc_step;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   c_next;

    assign accept    = start && (state_q != RUN);
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(1));

`ifdef MUL_ITER_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;

    assign a_neg = sign & A[WIDTH-1];
    assign b_neg = sign & B[WIDTH-1];
    // Sign-extend before negating so the most-negative value yields a
    // correct positive magnitude of 2^(WIDTH-1).
    assign a_mag = a_neg ? -{A[WIDTH-1], A} : {1'b0, A};
    // In WIDTH bits, -(most-negative) wraps to 2^(WIDTH-1) read as unsigned,
    // which is exactly the magnitude we want.
    assign b_mag = b_neg ? -B : B;
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign a_mag       = {1'b0, A};
    assign b_mag       = B;
`endif

    // One shift-add step: add the multiplicand if the current multiplier LSB
    // is set, then shift the whole accumulator right by one.
    assign sum      = {1'b0, acc_q[2*WIDTH:WIDTH]}
                    + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+2){1'b0}});
    assign acc_step = {sum, acc_q[WIDTH-1:1]};
    // The magnitude product always fits in 2*WIDTH bits, so the top bit is zero.
    assign prod     = acc_step[2*WIDTH-1:0];

`ifdef MUL_ITER_SIGNED_EN
    assign c_next = neg_q ? -prod : prod;
`else
    assign c_next = prod;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = start ? RUN : IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            C       <= '0;
`ifdef MUL_ITER_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q   <= CNT_W'(WIDTH);
            mcand_q <= a_mag;
            acc_q   <= {{(WIDTH+1){1'b0}}, b_mag};
`ifdef MUL_ITER_SIGNED_EN
            neg_q   <= a_neg ^ b_neg;
`endif
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CNT_W'(1);
            acc_q <= acc_step;
            if (last_step) begin
                C <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Randomized scoreboard bench for mul_iter (WIDTH=32).
// Latency: expected done edge derived from the acceptance edge plus WIDTH.
// Backpressure: bench models start acceptance (ignored while the DUT is running).

module tb_mul_iter;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_edge;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     a_in = '0;
    logic [W-1:0]     b_in = '0;
    logic             sign = 1'b0;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   C;

    int               edge_cnt = 0;
    int               run_until = 0;
    int               checks = 0;
    int               failures = 0;
    int               done_seen = 0;
    logic [2*W-1:0]   c_exp = '0;
    exp_t             q[$];

    mul_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .C     (C)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference product straight from the arithmetic definition.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        logic [2*W-1:0] r;
        r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef MUL_ITER_SIGNED_EN
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            r  = sa * sb;
        end
`else
        if (s) r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, expv, edge_cnt);
        end
    endtask

    // Drive one cycle of inputs for the next rising edge and predict its effect.
    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic r);
        int e;
        @(negedge clk);
        start = st;
        a_in  = a;
        b_in  = b;
        sign  = s;
        rst_n = r;
        e = edge_cnt + 1;
        if (!r) begin
            run_until = 0;
        end else if (st && e > run_until) begin
            q.push_back('{prod: model(a, b, s), done_edge: e + W});
            run_until = e + W;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, $urandom_range(0, 1), 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = 1;
            2: v = '1;
            3: v = {1'b1, {(W-1){1'b0}}};
            4: v = {1'b0, {(W-1){1'b1}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("reset_busy", {63'b0, busy}, '0);
                chk("reset_done", {63'b0, done}, '0);
                chk("reset_c", C, '0);
                q.delete();
                c_exp = '0;
            end else begin
                chk("busy", {63'b0, busy}, {63'b0, (q.size() > 0 && edge_cnt < q[0].done_edge)});
                chk("busy_done_excl", {63'b0, busy & done}, '0);
                if (done) begin
                    done_seen++;
                    if (q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("product", C, e.prod);
                        chk("done_edge", 64'(edge_cnt), 64'(e.done_edge));
                        c_exp = e.prod;
                    end
                end else if (q.size() > 0 && q[0].done_edge <= edge_cnt) begin
                    e = q.pop_front();
                    chk("missing_done", {63'b0, done}, 64'd1);
                    c_exp = e.prod;
                end
                chk("c_hold", C, c_exp);
            end
        end
    end

    initial begin
        int d0;
        // Reset for a few edges, with start asserted to show reset overrides it.
        drive(1'b1, '1, '1, 1'b0, 1'b0);
        drive(1'b1, '1, '1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Extreme operands, both modes.
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1); idle(W + 1);
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1); idle(W + 1);
        drive(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1); idle(W + 1);
        drive(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1); idle(W + 1);
        drive(1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b1); idle(W + 1);

        // Small values, then a zero product; exactly one done each.
        d0 = done_seen;
        drive(1'b1, 32'd321, 32'd640, 1'b0, 1'b1); idle(W + 1);
        drive(1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1); idle(W + 1);
        chk("done_count", 64'(done_seen - d0), 64'd2);

        // Start re-pulsed mid-run with new operands: must be ignored.
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
        idle(4);
        drive(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1);
        idle(W);

        // Start held high through DONE: back-to-back results.
        for (int i = 0; i < 2 * W + 3; i++) drive(1'b1, 32'h0000BEEF, 32'h00ABCDEF, 1'b0, 1'b1);
        idle(W + 2);

        // Reset in the middle of an operation, then restart on the next edge.
        drive(1'b1, 32'hFFFF0001, 32'h00010003, 1'b0, 1'b1);
        idle(9);
        drive(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
        drive(1'b1, 32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b1);
        idle(W + 2);

        // Random traffic with sporadic resets.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 2) == 0, pick(), pick(), $urandom_range(0, 1),
                  $urandom_range(0, 299) != 0);
        end
        idle(W + 3);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port start  input  1  request pulse; operands and mode sampled when accepted.
REQ-005 Port A  input  WIDTH  multiplicand.
REQ-006 Port B  input  WIDTH  multiplier.
REQ-007 Port sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 Port busy  output  1  high while in RUN.
REQ-009 Port done  output  1  one-cycle pulse; C valid with it.
REQ-010 Port C  output  2*WIDTH  product; held until the next completion.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE or DONE with start=1 at edge t SHALL latch A, B and sign, load the iteration counter with WIDTH, and enter RUN.
REQ-013 IDLE or DONE with start=0 SHALL go to IDLE.
REQ-014 RUN SHALL perform one radix-2 shift-add step per cycle and decrement the counter.
REQ-015 The final step SHALL occur at edge t+WIDTH, which writes C, enters DONE and asserts done for exactly that one cycle.
REQ-016 Latency SHALL be WIDTH cycles from the accepting edge to done; back-to-back requests (start during DONE) SHALL sustain one result per WIDTH+1 cycles.
REQ-017 start during RUN SHALL be ignored: no re-latch, no restart, and no change to the pending result.
REQ-018 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-019 Unsigned mode: C SHALL equal A*B exactly, zero-extended to 2*WIDTH bits with no truncation.
REQ-020 Signed mode: magnitudes SHALL be multiplied; C SHALL be negated when the operand signs differ.
REQ-021 Signed mode: the most-negative operand value SHALL be handled correctly, using a WIDTH+1-bit magnitude.
REQ-022 C SHALL change only at the edge that enters DONE, and SHALL be stable at all other times.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.

Reset
REQ-024 rst_n=0 at any edge SHALL force IDLE, busy=0, done=0, C=0 and counter=0, overriding start.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; a start on the first edge with rst_n=1 SHALL be accepted normally.

Configuration
REQ-026 Macro MUL_ITER_SIGNED_EN SHALL control signed support.
REQ-027 With MUL_ITER_SIGNED_EN defined, the sign port SHALL be honoured as in REQ-020 and REQ-021.
REQ-028 Without MUL_ITER_SIGNED_EN, the sign port SHALL remain present but be ignored, all operations SHALL be unsigned, and the sign-correction logic SHALL be absent.

Verification (WIDTH=32)
REQ-029 A=FFFFFFFF, B=FFFFFFFF, sign=0 -> done at t+32, C=FFFFFFFE00000001; with sign=1 and signed support built in -> C=0000000000000001.
REQ-030 A=7FFFFFFF, B=80000000: sign=1 -> C=C000000080000000; sign=0 -> C=3FFFFFFF80000000; without MUL_ITER_SIGNED_EN, sign=1 -> C=3FFFFFFF80000000.
REQ-031 A=321, B=640 -> C=205440 (0x32280); then A=FFFFFFFF, B=0 -> C=0 with exactly one done pulse per operation.
REQ-032 start re-pulsed at t+5 with new operands -> ignored, original product delivered at t+32; start held high through DONE -> second result at t+65.
REQ-033 rst_n=0 at t+10 of an operation -> busy=0, C=0, no done; start at the next edge -> correct result 32 cycles later.
